// File: rtl/adsr_pkg.sv
// Shared definitions for the polyphonic ADSR envelope generator.
// Holds the channel state encoding used by every channel instance.
package adsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_t;

endpackage

// File: rtl/adsr_chan.sv
// One ADSR envelope channel: gate edge detector, phase FSM and envelope register.
// Gate edges take priority over prescaler ticks; the envelope only moves on a tick.
module adsr_chan
    import adsr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         trig,
    input  logic [W-1:0] ai,
    input  logic [W-1:0] di,
    input  logic [W-1:0] s,
    input  logic [W-1:0] ri,
    output logic [W-1:0] env,
    output logic         busy
);

    localparam logic [W-1:0] ENV_MAX = '1;

    adsr_state_t  state, state_nxt;
    logic [W-1:0] env_nxt;
    logic         trig_q;
    logic         rise, fall;
    logic [W:0]   att_sum;
    logic [W:0]   dec_floor;

    assign rise      = trig & ~trig_q;
    assign fall      = ~trig & trig_q;
    // One extra bit so neither the attack sum nor the decay threshold can wrap.
    assign att_sum   = {1'b0, env} + {1'b0, ai};
    assign dec_floor = {1'b0, s} + {1'b0, di};
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            env    <= '0;
            trig_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            env    <= env_nxt;
            trig_q <= trig;
        end
    end

    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        if (rise) begin
            state_nxt = ST_ATTACK;
        end else if (fall && (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)) begin
            state_nxt = ST_RELEASE;
        end else if (tick) begin
            case (state)
                ST_ATTACK: begin
                    if (ai == '0 || att_sum >= {1'b0, ENV_MAX}) begin
                        env_nxt   = ENV_MAX;
                        state_nxt = ST_DECAY;
                    end else begin
                        env_nxt = att_sum[W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (di == '0 || env <= s || {1'b0, env} <= dec_floor) begin
                        env_nxt   = s;
                        state_nxt = ST_SUSTAIN;
                    end else begin
                        env_nxt = env - di;
                    end
                end
                ST_SUSTAIN: env_nxt = s;
                ST_RELEASE: begin
                    if (ri == '0 || env <= ri) begin
                        env_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        env_nxt = env - ri;
                    end
                end
                default: begin
                    env_nxt   = '0;
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/adsr_poly.sv
// Polyphonic ADSR: shared tick prescaler, CH independent channels and a registered mixer.
// The mixer sums the registered channel envelopes, so it lags them by one clock.
module adsr_poly
    import adsr_pkg::*;
#(
    parameter int CH = 4,
    parameter int W  = 8,
    parameter int PW = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CH-1:0]             trig,
    input  logic [W-1:0]              ai,
    input  logic [W-1:0]              di,
    input  logic [W-1:0]              s,
    input  logic [W-1:0]              ri,
    input  logic [PW-1:0]             presc,
    output logic [CH*W-1:0]           envelope,
    output logic [CH-1:0]             busy,
    output logic [W+$clog2(CH)-1:0]   mix
);

    localparam int MW = W + $clog2(CH);

    logic [PW-1:0] cnt;
    logic          tick;
    logic [MW-1:0] mix_sum;

    assign tick = (cnt == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        adsr_chan #(.W(W)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .tick  (tick),
            .trig  (trig[i]),
            .ai    (ai),
            .di    (di),
            .s     (s),
            .ri    (ri),
            .env   (envelope[i*W +: W]),
            .busy  (busy[i])
        );
    end

    always_comb begin
        mix_sum = '0;
        for (int i = 0; i < CH; i++) begin
            mix_sum = mix_sum + MW'(envelope[i*W +: W]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix <= '0;
        end else begin
            mix <= mix_sum;
        end
    end

endmodule

// File: tb/tb_adsr_poly.sv
// Self-checking bench for adsr_poly (CH=2, W=8, PW=8): directed scenarios plus
// randomized gate/rate traffic, all checked against an integer envelope model.
module tb_adsr_poly;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int PW = 8;

    localparam int M_IDLE = 0;
    localparam int M_ATT  = 1;
    localparam int M_DEC  = 2;
    localparam int M_SUS  = 3;
    localparam int M_REL  = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   trig;
    logic [W-1:0]    ai, di, s, ri;
    logic [PW-1:0]   presc;
    logic [CH*W-1:0] envelope;
    logic [CH-1:0]   busy;
    logic [W:0]      mix;

    int n_cmp  = 0;
    int n_fail = 0;

    int m_env [CH];
    int m_st  [CH];
    bit m_tq  [CH];
    int m_cnt;
    int m_mix;

    adsr_poly #(.CH(CH), .W(W), .PW(PW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .trig     (trig),
        .ai       (ai),
        .di       (di),
        .s        (s),
        .ri       (ri),
        .presc    (presc),
        .envelope (envelope),
        .busy     (busy),
        .mix      (mix)
    );

    always #5 clk = ~clk;

    // Reference model: one envelope phase step per clock, written from the phase rules.
    function automatic void next_chan(input int st, input int env, input bit rs, input bit fl,
                                      input bit tk, output int nst, output int nenv);
        int a, d, sl, r;
        a = ai; d = di; sl = s; r = ri;
        nst = st;
        nenv = env;
        if (rs) begin
            nst = M_ATT;
        end else if (fl && (st == M_ATT || st == M_DEC || st == M_SUS)) begin
            nst = M_REL;
        end else if (tk) begin
            if (st == M_ATT) begin
                if (a == 0 || env + a >= 255) begin nenv = 255; nst = M_DEC; end
                else nenv = env + a;
            end else if (st == M_DEC) begin
                if (d == 0 || env <= sl || env - d <= sl) begin nenv = sl; nst = M_SUS; end
                else nenv = env - d;
            end else if (st == M_SUS) begin
                nenv = sl;
            end else if (st == M_REL) begin
                if (r == 0 || env <= r) begin nenv = 0; nst = M_IDLE; end
                else nenv = env - r;
            end else begin
                nenv = 0;
            end
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int nst, nenv;
        bit tk;
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                m_env[i] <= 0;
                m_st[i]  <= M_IDLE;
                m_tq[i]  <= 1'b0;
            end
            m_cnt <= 0;
            m_mix <= 0;
        end else begin
            tk = (m_cnt == int'(presc));
            m_cnt <= tk ? 0 : (m_cnt + 1) % 256;
            for (int i = 0; i < CH; i++) begin
                next_chan(m_st[i], m_env[i], trig[i] & ~m_tq[i], ~trig[i] & m_tq[i], tk, nst, nenv);
                m_st[i]  <= nst;
                m_env[i] <= nenv;
                m_tq[i]  <= trig[i];
            end
            m_mix <= m_env[0] + m_env[1];
        end
    end

    function automatic logic [CH*W-1:0] exp_envelope();
        return {8'(m_env[1]), 8'(m_env[0])};
    endfunction

    function automatic logic [CH-1:0] exp_busy();
        return {m_st[1] != M_IDLE, m_st[0] != M_IDLE};
    endfunction

    function automatic logic [W:0] exp_mix();
        return 9'(m_mix);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        trig  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        trig  = 2'b11;
        ai = 8'($urandom); di = 8'($urandom); s = 8'($urandom); ri = 8'($urandom);
        presc = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({envelope, busy, mix} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_hold got env=%h busy=%b mix=%0d want all zero", envelope, busy, mix);
        end
        trig  = 2'b01;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 2'b01 || envelope !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_release_rise got busy=%b env=%h want busy=01 env=0000", busy, envelope);
        end
        trig = 2'b00;
    endtask

    task automatic test_full_envelope();
        presc = 8'd0; ai = 8'd5; di = 8'd10; s = 8'd64; ri = 8'd1;
        do_reset();
        trig = 2'b01;
        @(negedge clk);
        for (int k = 0; k < 81; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({envelope, busy, mix} !== {exp_envelope(), exp_busy(), exp_mix()}) begin
                n_fail++;
                $display("[TB] FAIL adsr_model got env=%h busy=%b mix=%0d want env=%h busy=%b mix=%0d",
                         envelope, busy, mix, exp_envelope(), exp_busy(), exp_mix());
            end
            if (k == 50 || k == 70 || k == 80) begin
                n_cmp++;
                if (envelope[7:0] !== (k == 50 ? 8'd255 : 8'd64)) begin
                    n_fail++;
                    $display("[TB] FAIL adsr_level tick%0d got %0d want %0d", k + 1, envelope[7:0],
                             (k == 50 ? 255 : 64));
                end
            end
        end
        trig = 2'b00;
        @(negedge clk);
        repeat (63) @(negedge clk);
        n_cmp++;
        if (envelope[7:0] !== 8'd1 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL release_63 got env0=%0d busy0=%b want 1 1", envelope[7:0], busy[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (envelope[7:0] !== 8'd0 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL release_end got env0=%0d busy0=%b want 0 0", envelope[7:0], busy[0]);
        end
    endtask

    task automatic test_prescaler();
        logic [7:0] prev;
        int gap, changes;
        presc = 8'd3; ai = 8'd5; di = 8'd10; s = 8'd64; ri = 8'd1;
        do_reset();
        trig = 2'b01;
        @(negedge clk);
        prev = envelope[7:0];
        gap = 0;
        changes = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            gap++;
            if (envelope[7:0] !== prev) begin
                n_cmp++;
                if (envelope[7:0] !== prev + 8'd5 || (changes > 0 && gap != 4)) begin
                    n_fail++;
                    $display("[TB] FAIL presc_step got %0d after %0d clocks want %0d after 4",
                             envelope[7:0], gap, prev + 8'd5);
                end
                changes++;
                gap = 0;
                prev = envelope[7:0];
            end
        end
        n_cmp++;
        if (envelope[7:0] !== 8'd50 || envelope[15:8] !== 8'd0 || busy[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL presc_total got env0=%0d env1=%0d busy1=%b want 50 0 0",
                     envelope[7:0], envelope[15:8], busy[1]);
        end
        trig = 2'b00;
    endtask

    task automatic test_retrigger();
        int waited;
        presc = 8'd0; ai = 8'd5; di = 8'd10; s = 8'd64; ri = 8'd1;
        do_reset();
        trig = 2'b01;
        repeat (80) @(negedge clk);
        trig = 2'b00;
        waited = 0;
        while (envelope[7:0] !== 8'd54 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (waited >= 100) begin
            n_fail++;
            $display("[TB] FAIL retrig_wait got env0=%0d want 54 within 100 clocks", envelope[7:0]);
        end
        trig = 2'b01;
        @(negedge clk);
        n_cmp++;
        if (envelope[7:0] !== 8'd54 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL retrig_hold got env0=%0d busy0=%b want 54 1", envelope[7:0], busy[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (envelope[7:0] !== 8'd59) begin
            n_fail++;
            $display("[TB] FAIL retrig_step got env0=%0d want 59", envelope[7:0]);
        end
        trig = 2'b00;
    endtask

    task automatic test_zero_rates();
        logic [7:0] want [6];
        want = '{8'd0, 8'd255, 8'd64, 8'd64, 8'd64, 8'd0};
        presc = 8'd0; ai = 8'd0; di = 8'd0; s = 8'd64; ri = 8'd0;
        do_reset();
        trig = 2'b01;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) trig = 2'b00;
            @(negedge clk);
            n_cmp++;
            if (envelope[7:0] !== want[k]) begin
                n_fail++;
                $display("[TB] FAIL zero_rates step%0d got %0d want %0d", k, envelope[7:0], want[k]);
            end
        end
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_rates_idle got busy0=%b want 0", busy[0]);
        end
    endtask

    task automatic test_mix_and_async_reset();
        presc = 8'd0; ai = 8'd255; di = 8'd1; s = 8'd0; ri = 8'd1;
        do_reset();
        trig = 2'b11;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (envelope !== 16'hFFFF) begin
            n_fail++;
            $display("[TB] FAIL mix_peak got env=%h want ffff", envelope);
        end
        @(negedge clk);
        n_cmp++;
        if (mix !== 9'd510) begin
            n_fail++;
            $display("[TB] FAIL mix_510 got %0d want 510", mix);
        end
        ai = 8'd1;
        do_reset();
        trig = 2'b11;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (envelope !== 16'h0000 || busy !== 2'b00 || mix !== 9'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got env=%h busy=%b mix=%0d want 0 0 0", envelope, busy, mix);
        end
        @(negedge clk);
        trig  = 2'b00;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({envelope, busy, mix} !== {exp_envelope(), exp_busy(), exp_mix()}) begin
                n_fail++;
                $display("[TB] FAIL random_model cyc%0d got env=%h busy=%b mix=%0d want env=%h busy=%b mix=%0d",
                         k, envelope, busy, mix, exp_envelope(), exp_busy(), exp_mix());
            end
            if (k % 500 == 0) begin
                rst_n = 1'b0;
                presc = 8'($urandom_range(0, 3));
            end else begin
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) trig[$urandom_range(0, 1)] ^= 1'b1;
            case ($urandom_range(0, 63))
                0: ai = 8'($urandom_range(0, 40));
                1: di = 8'($urandom_range(0, 40));
                2: s  = 8'($urandom);
                3: ri = 8'($urandom_range(0, 40));
                4: ai = 8'($urandom);
                5: ri = 8'($urandom);
                default: ;
            endcase
        end
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_full_envelope();
        test_prescaler();
        test_retrigger();
        test_zero_rates();
        test_mix_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
